// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/wb
// and drives ALU opcode, datapath selects and write enables.
module mc_ctrl_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zf,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       iord,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [3:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal,
  output logic       halted
);

  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DCD    = 4'd2;
  localparam logic [3:0] S_EXE    = 4'd3;
  localparam logic [3:0] S_WB_ALU = 4'd4;
  localparam logic [3:0] S_MA     = 4'd5;
  localparam logic [3:0] S_MR     = 4'd6;
  localparam logic [3:0] S_WB_MEM = 4'd7;
  localparam logic [3:0] S_MW     = 4'd8;
  localparam logic [3:0] S_BR     = 4'd9;
  localparam logic [3:0] S_JMP    = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd11;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [3:0] state;
  logic [3:0] nxt;

  logic       is_r;
  logic       is_jr;
  logic       r_ok;
  logic       is_imm;
  logic       is_mem;
  logic       is_br;
  logic       is_jmp;
  logic       zext;
  logic [3:0] r_alu;
  logic [3:0] i_alu;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = 4'd0;
    case (funct)
      6'b100000: r_alu = 4'd3;
      6'b100001: r_alu = 4'd0;
      6'b100010: r_alu = 4'd4;
      6'b100011: r_alu = 4'd1;
      6'b100100: r_alu = 4'd5;
      6'b100101: r_alu = 4'd6;
      6'b100110: r_alu = 4'd7;
      6'b100111: r_alu = 4'd8;
      6'b101010: r_alu = 4'd9;
      6'b101011: r_alu = 4'd10;
      default:   r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    is_imm = 1'b1;
    i_alu  = 4'd0;
    case (op)
      OP_ADDI:  i_alu  = 4'd11;
      OP_ADDIU: i_alu  = 4'd12;
      OP_ANDI:  i_alu  = 4'd13;
      OP_ORI:   i_alu  = 4'd2;
      OP_XORI:  i_alu  = 4'd14;
      default:  is_imm = 1'b0;
    endcase
  end

  assign is_r   = (op == OP_R);
  assign is_jr  = is_r && (funct == FN_JR);
  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign is_br  = (op == OP_BEQ) || (op == OP_BNE);
  assign is_jmp = (op == OP_J) || (op == OP_JAL) || is_jr;
  assign zext   = (op == OP_ANDI) || (op == OP_ORI) ||
                  (op == OP_XORI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= nxt;
  end

  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    iord       = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_op     = 1'b0;
    alu_op     = 4'd0;
    pc_src     = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    nxt        = S_RST;
    case (state)
      S_RST: nxt = S_FETCH;
      S_FETCH: begin
        ir_wr     = 1'b1;
        pc_wr     = 1'b1;
        alu_src_b = 2'd1;
        nxt       = S_DCD;
      end
      S_DCD: begin
        alu_src_b = 2'd3;
        ext_op    = 1'b1;
        // op classes are mutually exclusive by construction
        unique case (1'b1)
          (is_r && r_ok) || is_imm: nxt = S_EXE;
          is_mem:                   nxt = S_MA;
          is_br:                    nxt = S_BR;
          is_jmp:                   nxt = S_JMP;
          default: begin
            illegal = 1'b1;
            nxt     = ILLEGAL_TRAP ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_EXE: begin
        alu_src_a = 1'b1;
        if (is_r) begin
          alu_op = r_alu;
        end else begin
          alu_src_b = 2'd2;
          ext_op    = !zext;
          alu_op    = i_alu;
        end
        nxt = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_wr     = 1'b1;
        reg_dst    = is_r ? 2'd1 : 2'd0;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_MA: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        ext_op    = 1'b1;
        nxt       = (op == OP_LW) ? S_MR : S_MW;
      end
      S_MR: begin
        iord = 1'b1;
        nxt  = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_wr     = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_MW: begin
        iord       = 1'b1;
        mem_wr     = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_BR: begin
        alu_src_a  = 1'b1;
        alu_op     = 4'd1;
        pc_src     = 2'd1;
        pc_wr      = (op == OP_BEQ) ? zf : !zf;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_JMP: begin
        pc_wr      = 1'b1;
        instr_done = 1'b1;
        pc_src     = is_r ? 2'd3 : 2'd2;
        // PC already holds PC+4 here, so it is the link value
        if (op == OP_JAL) begin
          reg_wr     = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
        nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        nxt    = S_HALT;
      end
      default: nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: table of instructions checked cycle by
// cycle on both trap settings, plus illegal/halt and async-reset sequences.
module tb_mc_ctrl_fsm;

  typedef logic [21:0] ov_t;

  typedef struct packed {
    logic [5:0]      op;
    logic [5:0]      fn;
    logic            zf;
    logic [2:0]      n;
    logic [4:0][21:0] e;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zf;

  logic       pc_wr0, ir_wr0, iord0, mem_wr0, reg_wr0;
  logic [1:0] reg_dst0, mem_to_reg0, alu_src_b0, pc_src0;
  logic       alu_src_a0, ext_op0, instr_done0, illegal0, halted0;
  logic [3:0] alu_op0;

  logic       pc_wr1, ir_wr1, iord1, mem_wr1, reg_wr1;
  logic [1:0] reg_dst1, mem_to_reg1, alu_src_b1, pc_src1;
  logic       alu_src_a1, ext_op1, instr_done1, illegal1, halted1;
  logic [3:0] alu_op1;

  ov_t o0, o1;

  int ncmp = 0;
  int nbad = 0;

  mc_ctrl_fsm #(.ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zf(zf),
    .pc_wr(pc_wr0), .ir_wr(ir_wr0), .iord(iord0), .mem_wr(mem_wr0),
    .reg_wr(reg_wr0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .ext_op(ext_op0),
    .alu_op(alu_op0), .pc_src(pc_src0), .instr_done(instr_done0),
    .illegal(illegal0), .halted(halted0)
  );

  mc_ctrl_fsm #(.ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zf(zf),
    .pc_wr(pc_wr1), .ir_wr(ir_wr1), .iord(iord1), .mem_wr(mem_wr1),
    .reg_wr(reg_wr1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .ext_op(ext_op1),
    .alu_op(alu_op1), .pc_src(pc_src1), .instr_done(instr_done1),
    .illegal(illegal1), .halted(halted1)
  );

  assign o0 = {pc_wr0, ir_wr0, iord0, mem_wr0, reg_wr0, reg_dst0,
               mem_to_reg0, alu_src_a0, alu_src_b0, ext_op0, alu_op0,
               pc_src0, instr_done0, illegal0, halted0};
  assign o1 = {pc_wr1, ir_wr1, iord1, mem_wr1, reg_wr1, reg_dst1,
               mem_to_reg1, alu_src_a1, alu_src_b1, ext_op1, alu_op1,
               pc_src1, instr_done1, illegal1, halted1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ov_t mk(
    input logic pw, iw, io, mw, rw,
    input logic [1:0] rd, mr,
    input logic sa,
    input logic [1:0] sb,
    input logic ex,
    input logic [3:0] ao,
    input logic [1:0] ps,
    input logic dn, il, hl
  );
    return {pw, iw, io, mw, rw, rd, mr, sa, sb, ex, ao, ps, dn, il, hl};
  endfunction

  function automatic vec_t mkv(
    input logic [5:0] o, f,
    input logic z,
    input logic [2:0] n,
    input ov_t e0, e1, e2, e3, e4
  );
    vec_t v;
    v.op = o; v.fn = f; v.zf = z; v.n = n;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
    v.e[3] = e3; v.e[4] = e4;
    return v;
  endfunction

  task automatic chk(input string nm, input ov_t got, input ov_t exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk2(input string nm, input ov_t exp);
    chk({nm, "/t0"}, o0, exp);
    chk({nm, "/t1"}, o1, exp);
  endtask

  ov_t Z, F, D, DIL, H, WBR, WBI, MA, MR, WBM, MW, JJ, JAL, JR;
  vec_t tbl[16];

  function automatic ov_t exr(input logic [3:0] a);
    return mk(0,0,0,0,0, 0,0, 1, 0, 0, a, 0, 0,0,0);
  endfunction

  function automatic ov_t exi(input logic x, input logic [3:0] a);
    return mk(0,0,0,0,0, 0,0, 1, 2, x, a, 0, 0,0,0);
  endfunction

  function automatic ov_t brx(input logic pw);
    return mk(pw,0,0,0,0, 0,0, 1, 0, 0, 4'd1, 1, 1,0,0);
  endfunction

  task automatic run(input int k);
    op    = tbl[k].op;
    funct = tbl[k].fn;
    zf    = tbl[k].zf;
    for (int c = 0; c < int'(tbl[k].n); c++) begin
      #1;
      chk($sformatf("v%0d c%0d", k, c), o0, tbl[k].e[c]);
      chk($sformatf("v%0d c%0d t1", k, c), o1, tbl[k].e[c]);
      @(negedge clk);
    end
  endtask

  initial begin
    Z   = '0;
    F   = mk(1,1,0,0,0, 0,0, 0, 1, 0, 0, 0, 0,0,0);
    D   = mk(0,0,0,0,0, 0,0, 0, 3, 1, 0, 0, 0,0,0);
    DIL = mk(0,0,0,0,0, 0,0, 0, 3, 1, 0, 0, 0,1,0);
    H   = mk(0,0,0,0,0, 0,0, 0, 0, 0, 0, 0, 0,0,1);
    WBR = mk(0,0,0,0,1, 1,0, 0, 0, 0, 0, 0, 1,0,0);
    WBI = mk(0,0,0,0,1, 0,0, 0, 0, 0, 0, 0, 1,0,0);
    MA  = mk(0,0,0,0,0, 0,0, 1, 2, 1, 0, 0, 0,0,0);
    MR  = mk(0,0,1,0,0, 0,0, 0, 0, 0, 0, 0, 0,0,0);
    WBM = mk(0,0,0,0,1, 0,1, 0, 0, 0, 0, 0, 1,0,0);
    MW  = mk(0,0,1,1,0, 0,0, 0, 0, 0, 0, 0, 1,0,0);
    JJ  = mk(1,0,0,0,0, 0,0, 0, 0, 0, 0, 2, 1,0,0);
    JAL = mk(1,0,0,0,1, 2,2, 0, 0, 0, 0, 2, 1,0,0);
    JR  = mk(1,0,0,0,0, 0,0, 0, 0, 0, 0, 3, 1,0,0);

    tbl[0]  = mkv(6'h00, 6'b100001, 0, 4, F, D, exr(0),  WBR, Z);
    tbl[1]  = mkv(6'h00, 6'b100010, 0, 4, F, D, exr(4),  WBR, Z);
    tbl[2]  = mkv(6'h00, 6'b101010, 0, 4, F, D, exr(9),  WBR, Z);
    tbl[3]  = mkv(6'h00, 6'b100111, 0, 4, F, D, exr(8),  WBR, Z);
    tbl[4]  = mkv(6'h00, 6'b101011, 0, 4, F, D, exr(10), WBR, Z);
    tbl[5]  = mkv(6'b001101, 6'h3f, 0, 4, F, D, exi(0, 2),  WBI, Z);
    tbl[6]  = mkv(6'b001000, 6'h00, 0, 4, F, D, exi(1, 11), WBI, Z);
    tbl[7]  = mkv(6'b001100, 6'h00, 0, 4, F, D, exi(0, 13), WBI, Z);
    tbl[8]  = mkv(6'b100011, 6'h00, 0, 5, F, D, MA, MR, WBM);
    tbl[9]  = mkv(6'b101011, 6'h00, 0, 4, F, D, MA, MW, Z);
    tbl[10] = mkv(6'b000100, 6'h00, 1, 3, F, D, brx(1), Z, Z);
    tbl[11] = mkv(6'b000100, 6'h00, 0, 3, F, D, brx(0), Z, Z);
    tbl[12] = mkv(6'b000101, 6'h00, 0, 3, F, D, brx(1), Z, Z);
    tbl[13] = mkv(6'b000101, 6'h00, 1, 3, F, D, brx(0), Z, Z);
    tbl[14] = mkv(6'b000011, 6'h00, 0, 3, F, D, JAL, Z, Z);
    tbl[15] = mkv(6'h00, 6'b001000, 0, 3, F, D, JR, Z, Z);

    rst_n = 1'b0;
    op    = '0;
    funct = '0;
    zf    = 1'b0;

    @(negedge clk);
    #1 chk2("in_reset", Z);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk2("rst_state", Z);
    @(negedge clk);

    for (int k = 0; k < 16; k++) run(k);

    // plain jump, reusing the table mechanism
    tbl[0] = mkv(6'b000010, 6'h00, 0, 3, F, D, JJ, Z, Z);
    run(0);

    // illegal opcode: trap=0 returns to FETCH, trap=1 halts
    op = 6'b111111;
    #1 chk2("ill_fetch", F);
    @(negedge clk);
    #1 chk2("ill_dcd", DIL);
    @(negedge clk);
    op    = 6'h00;
    funct = 6'b100001;
    #1;
    chk("ill_next t0", o0, F);
    chk("ill_next t1", o1, H);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1 chk($sformatf("halt_hold %0d", i), o1, H);
    end
    rst_n = 1'b0;
    #1 chk2("halt_rst", Z);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk2("halt_rel", Z);
    @(negedge clk);
    #1 chk2("halt_refetch", F);
    @(negedge clk);
    op = 6'h00;
    funct = 6'b100001;
    #1 chk2("post_halt_dcd", D);
    @(negedge clk);
    #1 chk2("post_halt_exe", exr(0));
    @(negedge clk);
    #1 chk2("post_halt_wb", WBR);
    @(negedge clk);

    // async reset in the middle of a store
    op = 6'b101011;
    #1 chk2("sw_f", F);
    @(negedge clk);
    #1 chk2("sw_d", D);
    @(negedge clk);
    #1 chk2("sw_ma", MA);
    @(negedge clk);
    #1 chk2("sw_mw", MW);
    #2 rst_n = 1'b0;
    #1 chk2("sw_async_drop", Z);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk2("sw_rel_rst", Z);
    @(negedge clk);
    #1 chk2("sw_refetch", F);
    @(negedge clk);
    op = 6'h00;
    funct = 6'b100100;
    #1 chk2("after_d", D);
    @(negedge clk);
    #1 chk2("after_exe_and", exr(5));
    @(negedge clk);
    #1 chk2("after_wb", WBR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
